// File: rtl/gpio_pkg.sv
// ---------------------------------------------------------------------------
// gpio_pkg
// Shared constants for the GPIO interrupt core: register indices on the
// 5-bit reg_addr bus and the fixed width of the register data path.
// No ports (package).
// ---------------------------------------------------------------------------
package gpio_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int BUS_W      = 32;

  localparam logic [REG_ADDR_W-1:0] ADDR_DATA_IN    = 5'd0;
  localparam logic [REG_ADDR_W-1:0] ADDR_DATA_OUT   = 5'd1;
  localparam logic [REG_ADDR_W-1:0] ADDR_DIR        = 5'd2;
  localparam logic [REG_ADDR_W-1:0] ADDR_RISE_EN    = 5'd3;
  localparam logic [REG_ADDR_W-1:0] ADDR_FALL_EN    = 5'd4;
  localparam logic [REG_ADDR_W-1:0] ADDR_IRQ_STATUS = 5'd5;
  localparam logic [REG_ADDR_W-1:0] ADDR_DB_LIMIT   = 5'd6;

endpackage : gpio_pkg

// File: rtl/gpio_debounce.sv
// ---------------------------------------------------------------------------
// gpio_debounce
// One GPIO input bit: SYNC_STAGES-deep synchroniser followed by an optional
// debounce filter (compiled in when GPIO_DEBOUNCE_EN is defined).
//
// Ports
//   clk       in   clock, rising edge
//   reset     in   asynchronous, active-high reset
//   pin_in    in   asynchronous pad input
//   db_limit  in   DB_CNT_W  number of consecutive differing cycles needed
//                  before the filtered value follows (0 treated as 1)
//   f_out     out  filtered (or, without the filter, synchronised) value
// ---------------------------------------------------------------------------
module gpio_debounce
  import gpio_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pin_in,
  input  logic [DB_CNT_W-1:0] db_limit,
  output logic                f_out
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   sync_s;

  // Shift the pad value into the synchroniser chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin_in};
    sync_s = sync_q[SYNC_STAGES-1];
  end

  // Synchroniser flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  logic                f_q;
  logic                f_d;
  logic [DB_CNT_W-1:0] cnt_q;
  logic [DB_CNT_W-1:0] cnt_d;
  // One extra bit so the increment never wraps before the compare.
  logic [DB_CNT_W:0]   lim_s;
  logic [DB_CNT_W:0]   cnt_inc_s;

  // Count consecutive cycles where the synchronised value disagrees with f;
  // flip f on the cycle that completes the run, restart on any agreement.
  always_comb begin
    if (db_limit == '0) begin
      lim_s = (DB_CNT_W+1)'(1);
    end else begin
      lim_s = {1'b0, db_limit};
    end
    cnt_inc_s = {1'b0, cnt_q} + (DB_CNT_W+1)'(1);
    if (sync_s == f_q) begin
      f_d   = f_q;
      cnt_d = '0;
    end else if (cnt_inc_s >= lim_s) begin
      f_d   = ~f_q;
      cnt_d = '0;
    end else begin
      f_d   = f_q;
      cnt_d = cnt_inc_s[DB_CNT_W-1:0];
    end
  end

  // Filter state flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      f_q   <= f_d;
      cnt_q <= cnt_d;
    end
  end

  assign f_out = f_q;
`else
  logic unused_s;

  assign unused_s = ^db_limit;
  assign f_out    = sync_s;
`endif

endmodule : gpio_debounce

// File: rtl/gpio_irq_core.sv
// ---------------------------------------------------------------------------
// gpio_irq_core
// GPIO block with per-pin direction, output data, synchronised inputs and
// edge-triggered interrupt status (write-1-to-clear, set wins over clear).
// Optional input debounce filter is enabled with the macro GPIO_DEBOUNCE_EN;
// without it the DB_LIMIT register (address 6) reads 0 and ignores writes.
//
// Ports
//   clk       in   clock, rising edge
//   reset     in   asynchronous, active-high reset
//   cs        in   slot select
//   read      in   read strobe (reads have no side effects; unused)
//   write     in   write strobe
//   reg_addr  in   5   register index
//   wr_data   in   32  write data, bits above DATA_WIDTH ignored
//   rd_data   out  32  combinational read data, zero-extended
//   gpio_in   in   DATA_WIDTH  asynchronous pad inputs
//   gpio_out  out  DATA_WIDTH  DATA_OUT register
//   gpio_oe   out  DATA_WIDTH  DIR register (1 = drive)
//   irq       out  OR of IRQ_STATUS
// ---------------------------------------------------------------------------
module gpio_irq_core
  import gpio_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CNT_W    = 16,
  parameter int DB_DEFAULT  = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs,
  input  logic                  read,
  input  logic                  write,
  input  logic [REG_ADDR_W-1:0] reg_addr,
  input  logic [BUS_W-1:0]      wr_data,
  output logic [BUS_W-1:0]      rd_data,
  input  logic [DATA_WIDTH-1:0] gpio_in,
  output logic [DATA_WIDTH-1:0] gpio_out,
  output logic [DATA_WIDTH-1:0] gpio_oe,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [DATA_WIDTH-1:0] dir_q, dir_d;
  logic [DATA_WIDTH-1:0] rise_en_q, rise_en_d;
  logic [DATA_WIDTH-1:0] fall_en_q, fall_en_d;
  logic [DATA_WIDTH-1:0] irq_status_q, irq_status_d;
  logic [DATA_WIDTH-1:0] p_q, p_d;
  logic                  irq_q, irq_d;

  logic [DATA_WIDTH-1:0] f_s;
  logic [DATA_WIDTH-1:0] rise_s;
  logic [DATA_WIDTH-1:0] fall_s;
  logic [DATA_WIDTH-1:0] set_s;
  logic [DATA_WIDTH-1:0] clr_s;
  logic [DATA_WIDTH-1:0] wdata_s;
  logic                  wr_en_s;
  logic [DB_CNT_W-1:0]   db_limit_s;
  logic                  unused_s;

`ifdef GPIO_DEBOUNCE_EN
  logic [DB_CNT_W-1:0]   db_limit_q, db_limit_d;

  assign db_limit_s = db_limit_q;
  assign unused_s   = ^{read, wr_data};
`else
  assign db_limit_s = '0;
  assign unused_s   = ^{read, wr_data, DB_CNT_W'(DB_DEFAULT)};
`endif

  // Per-pin synchroniser and optional filter.
  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
    gpio_debounce #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_CNT_W   (DB_CNT_W)
    ) u_db (
      .clk     (clk),
      .reset   (reset),
      .pin_in  (gpio_in[i]),
      .db_limit(db_limit_s),
      .f_out   (f_s[i])
    );
  end

  // Register writes, edge detection and status update.
  always_comb begin
    wdata_s    = wr_data[DATA_WIDTH-1:0];
    wr_en_s    = cs & write;
    data_out_d = data_out_q;
    dir_d      = dir_q;
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    clr_s      = '0;
`ifdef GPIO_DEBOUNCE_EN
    db_limit_d = db_limit_q;
`endif
    if (wr_en_s) begin
      case (reg_addr)
        ADDR_DATA_OUT:   data_out_d = wdata_s;
        ADDR_DIR:        dir_d      = wdata_s;
        ADDR_RISE_EN:    rise_en_d  = wdata_s;
        ADDR_FALL_EN:    fall_en_d  = wdata_s;
        ADDR_IRQ_STATUS: clr_s      = wdata_s;
`ifdef GPIO_DEBOUNCE_EN
        ADDR_DB_LIMIT:   db_limit_d = wr_data[DB_CNT_W-1:0];
`endif
        default:         clr_s      = '0;
      endcase
    end else begin
      clr_s = '0;
    end

    p_d    = f_s;
    rise_s = f_s & ~p_q;
    fall_s = ~f_s & p_q;
    set_s  = (rise_s & rise_en_q) | (fall_s & fall_en_q);
    // Clear first, then OR in new events so a same-cycle set survives.
    irq_status_d = (irq_status_q & ~clr_s) | set_s;
    irq_d        = |irq_status_d;
  end

  // Register state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out_q   <= '0;
      dir_q        <= '0;
      rise_en_q    <= '0;
      fall_en_q    <= '0;
      irq_status_q <= '0;
      p_q          <= '0;
      irq_q        <= 1'b0;
    end else begin
      data_out_q   <= data_out_d;
      dir_q        <= dir_d;
      rise_en_q    <= rise_en_d;
      fall_en_q    <= fall_en_d;
      irq_status_q <= irq_status_d;
      p_q          <= p_d;
      irq_q        <= irq_d;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  // Debounce limit register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_limit_q <= DB_CNT_W'(DB_DEFAULT);
    end else begin
      db_limit_q <= db_limit_d;
    end
  end
`endif

  // Combinational read mux, zero-extended to the bus width.
  always_comb begin
    rd_data = 32'h0000_0000;
    case (reg_addr)
      ADDR_DATA_IN:    rd_data[DATA_WIDTH-1:0] = f_s;
      ADDR_DATA_OUT:   rd_data[DATA_WIDTH-1:0] = data_out_q;
      ADDR_DIR:        rd_data[DATA_WIDTH-1:0] = dir_q;
      ADDR_RISE_EN:    rd_data[DATA_WIDTH-1:0] = rise_en_q;
      ADDR_FALL_EN:    rd_data[DATA_WIDTH-1:0] = fall_en_q;
      ADDR_IRQ_STATUS: rd_data[DATA_WIDTH-1:0] = irq_status_q;
`ifdef GPIO_DEBOUNCE_EN
      ADDR_DB_LIMIT:   rd_data[DB_CNT_W-1:0]   = db_limit_q;
`endif
      default:         rd_data = 32'h0000_0000;
    endcase
  end

  assign gpio_out = data_out_q;
  assign gpio_oe  = dir_q;
  assign irq      = irq_q;

endmodule : gpio_irq_core

// File: doc/gpio_irq_core.md
GPIO_IRQ_CORE -- requirements
Module: gpio_irq_core

Interface
REQ-001 Parameter DATA_WIDTH, default 16: number of GPIO pins, legal range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: input synchroniser depth, legal range 2..4.
REQ-003 Parameter DB_CNT_W, default 16: debounce limit/counter width.
REQ-004 Parameter DB_DEFAULT, default 1000: reset value of the DB_LIMIT register.
REQ-005 clk  in  1  clock; all flops on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 cs  in  1  slot select.
REQ-008 read  in  1  read strobe; no side effects.
REQ-009 write  in  1  write strobe.
REQ-010 reg_addr  in  5  register index.
REQ-011 wr_data  in  32  write data; bits above DATA_WIDTH ignored.
REQ-012 rd_data  out  32  read data, zero-extended above DATA_WIDTH.
REQ-013 gpio_in  in  DATA_WIDTH  asynchronous pad inputs.
REQ-014 gpio_out  out  DATA_WIDTH  output values, driven from the DATA_OUT register.
REQ-015 gpio_oe  out  DATA_WIDTH  per-bit output enable (1 = drive), driven from the DIR register; the pad tristate lives at top level.
REQ-016 irq  out  1  level interrupt, equal to the OR of IRQ_STATUS.

Function
REQ-017 The register map (reg_addr) SHALL be: 0 DATA_IN (RO), 1 DATA_OUT (RW), 2 DIR (RW), 3 RISE_EN (RW), 4 FALL_EN (RW), 5 IRQ_STATUS (RO, write-1-to-clear), 6 DB_LIMIT (RW).
REQ-018 A register SHALL be written on the clock edge where cs && write and reg_addr matches; writes to RO or unmapped addresses are ignored.
REQ-019 rd_data SHALL be combinational from reg_addr alone (cs/read not required); unmapped addresses read 0.
REQ-020 DATA_OUT writes SHALL take effect regardless of DIR.
REQ-021 Each gpio_in bit SHALL pass through a SYNC_STAGES flop chain; the chain output feeds the filter stage, whose output is f.
REQ-022 DATA_IN SHALL read f.
REQ-023 The edge detector SHALL hold p <= f each cycle; rise = f & ~p; fall = ~f & p.
REQ-024 IRQ_STATUS[i] SHALL set on the edge where (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]), for every bit independent of DIR.
REQ-025 Without filtering, latency SHALL be: a gpio_in change stable before edge 1 appears in DATA_IN after edge SYNC_STAGES, and sets status at edge SYNC_STAGES+1.
REQ-026 On a W1C write, a status bit being cleared and set in the same cycle SHALL end set (set wins).
REQ-027 Clearing RISE_EN or FALL_EN SHALL NOT clear already-set status bits.

Reset
REQ-028 On reset SHALL be 0: DATA_OUT, DIR, RISE_EN, FALL_EN, IRQ_STATUS, sync chains, f, p, debounce counters; thus gpio_out = 0, gpio_oe = 0, irq = 0.
REQ-029 On reset DB_LIMIT SHALL load DB_DEFAULT.
REQ-030 Reset asserted mid-debounce SHALL discard the count; no status bit sets on the first cycle after reset deassertion.

Configuration
REQ-031 With macro GPIO_DEBOUNCE_EN defined, f[i] SHALL change only after the synchronised value differs from f[i] for DB_LIMIT consecutive cycles; a matching cycle zeroes counter i; DB_LIMIT = 0 behaves as 1.
REQ-032 With GPIO_DEBOUNCE_EN undefined, f SHALL equal the synchroniser output, address 6 reads 0, and writes to address 6 are ignored.

Structure
REQ-033 Package gpio_pkg SHALL hold the register-address localparams (ADDR_DATA_IN..ADDR_DB_LIMIT).
REQ-034 Sub-module gpio_debounce (one bit: synchroniser plus optional filter) SHALL be instantiated DATA_WIDTH times via generate.

Verification
REQ-035 Write DIR=0x00FF, DATA_OUT=0xA5A5 -> gpio_oe=0x00FF, gpio_out=0xA5A5; reads of addr 1 and 2 return the same values.
REQ-036 No debounce, RISE_EN=0x0001, gpio_in[0] 0->1 -> IRQ_STATUS=0x0001 and irq=1 exactly SYNC_STAGES+1 edges later; W1C 0x0001 -> irq=0 next cycle.
REQ-037 FALL_EN=0x8000, gpio_in[15] 1->0 on the same cycle as a W1C 0x8000 that causes the set -> status bit 15 remains 1.
REQ-038 GPIO_DEBOUNCE_EN, DB_LIMIT=4: a 3-cycle pulse -> DATA_IN unchanged, no irq; a 4-cycle-stable change -> DATA_IN updates.
REQ-039 Reset asserted with gpio_in=0xFFFF and RISE_EN=0xFFFF (set prior) -> after deassertion all registers read reset values and DB_LIMIT reads 1000.
REQ-040 DATA_WIDTH=8 build: write 0xFFFFFFFF to DATA_OUT -> read returns 0x000000FF; read of addr 7 returns 0.
